// File: rtl/seq_divider.sv
// seq_divider: iterative restoring divider, one quotient bit per clock, start/ready handshake
module seq_divider #(
  parameter int WIDTH_M = 16,
  parameter int WIDTH_P = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH_P-1:0] dividend,
  input  logic [WIDTH_M-1:0] divisor,
  output logic [WIDTH_P-1:0] quotient,
  output logic [WIDTH_M-1:0] remainder,
  output logic               ready,
  output logic               div_by_zero
);
  localparam int CW = $clog2(WIDTH_P) + 1;
  typedef enum logic {IDLE, BUSY} state_e;
  state_e             state_q, state_d;
  logic [WIDTH_P-1:0] dq_q, dq_d, quo_q, quo_d;
  logic [WIDTH_M-1:0] r_q, r_d, dvs_q, dvs_d, rem_q, rem_d, r_sub;
  logic [WIDTH_M:0]   t;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               dbz_q, dbz_d, ge, last;
  // restoring step: shift next dividend bit into the partial remainder, trial-subtract the divisor
  // (a kept remainder is always below the divisor, so it fits in WIDTH_M bits)
  always_comb begin
    t = {r_q, dq_q[WIDTH_P-1]};
    ge = t >= {1'b0, dvs_q};
    r_sub = t[WIDTH_M-1:0] - dvs_q;
    last = cnt_q == CW'(WIDTH_P - 1);
  end
  // state register and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      dq_q <= '0;
      r_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dbz_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dq_q <= dq_d;
      r_q <= r_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      dbz_q <= dbz_d;
    end
  end
  // next state: a zero divisor completes immediately without leaving IDLE
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE) state_d = (start && divisor != '0) ? BUSY : IDLE;
    else state_d = last ? IDLE : BUSY;
  end
  // datapath next values: load on accept, step while busy, publish results on the final step
  always_comb begin
    dq_d = dq_q;
    r_d = r_q;
    dvs_d = dvs_q;
    cnt_d = cnt_q;
    quo_d = quo_q;
    rem_d = rem_q;
    dbz_d = dbz_q;
    if (state_q == IDLE && start) begin
      if (divisor == '0) begin
        quo_d = '1;
        rem_d = '0;
        dbz_d = 1'b1;
      end else begin
        dq_d = dividend;
        r_d = '0;
        dvs_d = divisor;
        cnt_d = '0;
        dbz_d = 1'b0;
      end
    end else if (state_q == BUSY) begin
      dq_d = {dq_q[WIDTH_P-2:0], ge};
      r_d = ge ? r_sub : t[WIDTH_M-1:0];
      cnt_d = cnt_q + 1'b1;
      if (last) begin
        quo_d = dq_d;
        rem_d = r_d;
      end
    end
  end
  // outputs: results hold between operations, ready means idle
  always_comb begin
    ready = state_q == IDLE;
    quotient = quo_q;
    remainder = rem_q;
    div_by_zero = dbz_q;
  end
endmodule
